// File: rtl/tft_spi_cmd_receiver.sv
// TFT SPI responder: deserializes {RS, 16-bit} frames into register and GRAM pixel writes.
// Optional macro TFT_RX_SHADOW_EN adds a 256x16 readable shadow of all register writes.
module tft_spi_cmd_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int H_END_RST   = 175,
  parameter int V_END_RST   = 219
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SCK,
  input  logic        MOSI,
  input  logic        RS,
  input  logic        CS,
  output logic        REG_WE,
  output logic [7:0]  REG_ADDR,
  output logic [15:0] REG_DATA,
  output logic        PIX_VALID,
  output logic [15:0] PIX_DATA,
  output logic [7:0]  PIX_X,
  output logic [7:0]  PIX_Y,
  output logic        FRAME_DONE
`ifdef TFT_RX_SHADOW_EN
  ,
  input  logic [7:0]  SHADOW_RADDR,
  output logic [15:0] SHADOW_RDATA
`endif
);

  localparam logic [7:0] H_END_INIT = 8'(H_END_RST);
  localparam logic [7:0] V_END_INIT = 8'(V_END_RST);

  // Pin bundle order {sck, mosi, rs, cs}; cs resets high so nothing is selected.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic sck_s, mosi_s, rs_s, cs_s;
  logic sck_d, rise_q, mosi_q, rs_q, cs_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0001;
    end else begin
      sync_q[0] <= {SCK, MOSI, RS, CS};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {sck_s, mosi_s, rs_s, cs_s} = sync_q[SYNC_STAGES-1];

  // Edge detect is registered together with data/rs/cs so all stay aligned.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sck_d  <= 1'b0;
      rise_q <= 1'b0;
      mosi_q <= 1'b0;
      rs_q   <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sck_d  <= sck_s;
      rise_q <= sck_s & ~sck_d;
      mosi_q <= mosi_s;
      rs_q   <= rs_s;
      cs_q   <= cs_s;
    end
  end

  logic [3:0]  bit_cnt;
  logic [14:0] shift_reg;
  logic        word_done;
  logic        word_rs;
  logic [15:0] word_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      word_done <= 1'b0;
      word_rs   <= 1'b0;
      word_q    <= '0;
    end else begin
      word_done <= 1'b0;
      if (cs_q) begin
        bit_cnt <= '0;
      end else if (rise_q) begin
        shift_reg <= {shift_reg[13:0], mosi_q};
        bit_cnt   <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) begin
          word_done <= 1'b1;
          word_q    <= {shift_reg, mosi_q};
          word_rs   <= rs_q;
        end
      end
    end
  end

  logic [7:0] x, y, h_start, h_end, v_start, v_end;
  logic [7:0] x_adv, y_adv;
  logic       frame_end;

  // An x beyond h_end never matches, so it just wraps until it meets h_end again.
  always_comb begin
    frame_end = (x == h_end) && (y == v_end);
    x_adv     = x + 8'd1;
    y_adv     = y;
    if (x == h_end) begin
      x_adv = h_start;
      y_adv = (y == v_end) ? v_start : y + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      REG_WE     <= 1'b0;
      REG_ADDR   <= '0;
      REG_DATA   <= '0;
      PIX_VALID  <= 1'b0;
      PIX_DATA   <= '0;
      PIX_X      <= '0;
      PIX_Y      <= '0;
      FRAME_DONE <= 1'b0;
      x          <= '0;
      y          <= '0;
      h_start    <= '0;
      h_end      <= H_END_INIT;
      v_start    <= '0;
      v_end      <= V_END_INIT;
    end else begin
      REG_WE     <= 1'b0;
      PIX_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (word_done) begin
        if (!word_rs) begin
          REG_ADDR <= word_q[7:0];
        end else begin
          REG_WE   <= 1'b1;
          REG_DATA <= word_q;
          case (REG_ADDR)
            8'h20: x       <= word_q[7:0];
            8'h21: y       <= word_q[7:0];
            8'h36: h_end   <= word_q[7:0];
            8'h37: h_start <= word_q[7:0];
            8'h38: v_end   <= word_q[7:0];
            8'h39: v_start <= word_q[7:0];
            8'h22: begin
              PIX_VALID  <= 1'b1;
              PIX_DATA   <= word_q;
              PIX_X      <= x;
              PIX_Y      <= y;
              FRAME_DONE <= frame_end;
              x          <= x_adv;
              y          <= y_adv;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef TFT_RX_SHADOW_EN
  logic [15:0] shadow [256];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 256; i++)
        shadow[i] <= (i == 'h36) ? 16'(H_END_RST) : (i == 'h38) ? 16'(V_END_RST) : 16'h0;
      SHADOW_RDATA <= '0;
    end else begin
      if (REG_WE) shadow[REG_ADDR] <= REG_DATA;
      SHADOW_RDATA <= shadow[SHADOW_RADDR];
    end
  end
`endif

endmodule
